// File: rtl/ct_idu_mat_pipe8_issue.sv
// Issue-side launcher for matrix pipe8 (matrix ALU).
// Holds dispatched ALU instructions in an in-order queue and launches them into the
// RF-stage registers that feed EX1. The number of issued but uncompleted instructions
// is capped at MAX_OUTSTANDING and tracked through the EX1 completion bus.
// Optional: define MAT_PIPE8_IID_CHK_EN to add an in-order IID check on completions,
// reported on the sticky output idu_mat_pipe8_iid_err.
module ct_idu_mat_pipe8_issue #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        cpurst_b,
  input  logic        ctrl_clk,
  input  logic        rtu_yy_xx_flush,
  input  logic        dis_mat_pipe8_vld,
  input  logic [6:0]  dis_mat_pipe8_iid,
  input  logic [30:0] dis_mat_pipe8_meta,
  input  logic        dis_mat_pipe8_src0_vld,
  input  logic [63:0] dis_mat_pipe8_src0,
  output logic        idu_dis_mat_pipe8_rdy,
  output logic        idu_mat_rf_alu_sel,
  output logic        idu_mat_rf_alu_gateclk_sel,
  output logic [6:0]  idu_mat_rf_pipe8_iid,
  output logic [30:0] idu_mat_rf_pipe8_alu_meta,
  output logic        idu_mat_rf_pipe8_alu_src0_vld,
  output logic [63:0] idu_mat_rf_pipe8_alu_src0,
  input  logic        mat_alu_cbus_ex1_pipe8_sel,
  input  logic [6:0]  mat_alu_cbus_ex1_pipe8_iid,
  output logic        idu_mat_pipe8_idle
`ifdef MAT_PIPE8_IID_CHK_EN
  ,
  output logic        idu_mat_pipe8_iid_err
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned EW = 7 + 31 + 1 + 64;

  // Queue state: pointers carry one extra wrap bit to tell full from empty.
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] head;

  logic [OW-1:0] outst_q, outst_d;

  logic          full, empty, push, issue, cmpl, dec;

  // RF-stage launch registers.
  logic          alu_sel_q;
  logic [6:0]    rf_iid_q;
  logic [30:0]   rf_meta_q;
  logic          rf_src0_vld_q;
  logic [63:0]   rf_src0_q;

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == PW'(DEPTH));
  assign empty = (wr_ptr_q == rd_ptr_q);

  // Flush suppresses every state-changing event in its cycle.
  assign push  = dis_mat_pipe8_vld && !full && !rtu_yy_xx_flush;
  assign issue = !empty && (outst_q < OW'(MAX_OUTSTANDING)) && !rtu_yy_xx_flush;
  assign cmpl  = mat_alu_cbus_ex1_pipe8_sel && !rtu_yy_xx_flush;
  // A completion with nothing outstanding is a protocol error; the counter saturates.
  assign dec   = cmpl && (outst_q != '0);

  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // Queue storage: data only, no reset needed.
  always_ff @(posedge ctrl_clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {dis_mat_pipe8_iid, dis_mat_pipe8_meta,
                                  dis_mat_pipe8_src0_vld, dis_mat_pipe8_src0};
    end
  end

  // Next-state for queue pointers and the outstanding counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    outst_d  = outst_q;
    if (rtu_yy_xx_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      outst_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (issue) rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({issue, dec})
        2'b10:   outst_d = outst_q + OW'(1);
        2'b01:   outst_d = outst_q - OW'(1);
        default: outst_d = outst_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge ctrl_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      outst_q   <= '0;
      alu_sel_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      outst_q   <= outst_d;
      alu_sel_q <= issue;
    end
  end

  // RF data registers: loaded only on issue, otherwise hold (flush does not clear them).
  always_ff @(posedge ctrl_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rf_iid_q      <= '0;
      rf_meta_q     <= '0;
      rf_src0_vld_q <= 1'b0;
      rf_src0_q     <= '0;
    end else if (issue) begin
      {rf_iid_q, rf_meta_q, rf_src0_vld_q, rf_src0_q} <= head;
    end
  end

  assign idu_dis_mat_pipe8_rdy         = !full;
  assign idu_mat_rf_alu_sel            = alu_sel_q;
  assign idu_mat_rf_alu_gateclk_sel    = alu_sel_q;
  assign idu_mat_rf_pipe8_iid          = rf_iid_q;
  assign idu_mat_rf_pipe8_alu_meta     = rf_meta_q;
  assign idu_mat_rf_pipe8_alu_src0_vld = rf_src0_vld_q;
  assign idu_mat_rf_pipe8_alu_src0     = rf_src0_q;
  assign idu_mat_pipe8_idle            = empty && !alu_sel_q && (outst_q == '0);

`ifdef MAT_PIPE8_IID_CHK_EN
  localparam int unsigned FW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  // FIFO occupancy always equals outst_q, so only the head index is stored.
  logic [6:0]    iid_fifo_q [MAX_OUTSTANDING];
  logic [FW-1:0] fifo_hd_q, fifo_hd_d, fifo_wr_idx;
  logic          iid_err_q, iid_err_d;
  int unsigned   wr_sum;

  // Tail index and head advance, both modulo MAX_OUTSTANDING.
  always_comb begin
    wr_sum = 32'(fifo_hd_q) + 32'(outst_q);
    if (wr_sum >= MAX_OUTSTANDING) wr_sum = wr_sum - MAX_OUTSTANDING;
    fifo_wr_idx = FW'(wr_sum);
    fifo_hd_d   = fifo_hd_q;
    iid_err_d   = iid_err_q;
    if (rtu_yy_xx_flush) begin
      fifo_hd_d = '0;
    end else if (cmpl) begin
      if (outst_q == '0) begin
        iid_err_d = 1'b1;
      end else begin
        if (iid_fifo_q[fifo_hd_q] != mat_alu_cbus_ex1_pipe8_iid) iid_err_d = 1'b1;
        fifo_hd_d = (32'(fifo_hd_q) == MAX_OUTSTANDING - 1) ? '0 : fifo_hd_q + FW'(1);
      end
    end
  end

  // IID FIFO storage.
  always_ff @(posedge ctrl_clk) begin
    if (issue) iid_fifo_q[fifo_wr_idx] <= head[EW-1 -: 7];
  end

  // Head pointer and sticky error flag (only reset clears the flag).
  always_ff @(posedge ctrl_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      fifo_hd_q <= '0;
      iid_err_q <= 1'b0;
    end else begin
      fifo_hd_q <= fifo_hd_d;
      iid_err_q <= iid_err_d;
    end
  end

  assign idu_mat_pipe8_iid_err = iid_err_q;
`else
  // Completion IID is only consumed by the optional checker.
  logic unused_cbus_iid;
  assign unused_cbus_iid = ^mat_alu_cbus_ex1_pipe8_iid;
`endif

endmodule

// File: tb/tb_ct_idu_mat_pipe8_issue.sv
// Directed self-checking bench for ct_idu_mat_pipe8_issue (DEPTH=4, MAX_OUTSTANDING=2).
module tb_ct_idu_mat_pipe8_issue;

  logic        cpurst_b;
  logic        ctrl_clk;
  logic        flush;
  logic        dvld;
  logic [6:0]  diid;
  logic [30:0] dmeta;
  logic        ds0v;
  logic [63:0] ds0;
  logic        rdy;
  logic        sel;
  logic        gsel;
  logic [6:0]  rf_iid;
  logic [30:0] rf_meta;
  logic        rf_s0v;
  logic [63:0] rf_s0;
  logic        csel;
  logic [6:0]  ciid;
  logic        idle;
`ifdef MAT_PIPE8_IID_CHK_EN
  logic        iid_err;
`endif

  int errors = 0;
  int checks = 0;

  ct_idu_mat_pipe8_issue #(
    .DEPTH           (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .cpurst_b                      (cpurst_b),
    .ctrl_clk                      (ctrl_clk),
    .rtu_yy_xx_flush               (flush),
    .dis_mat_pipe8_vld             (dvld),
    .dis_mat_pipe8_iid             (diid),
    .dis_mat_pipe8_meta            (dmeta),
    .dis_mat_pipe8_src0_vld        (ds0v),
    .dis_mat_pipe8_src0            (ds0),
    .idu_dis_mat_pipe8_rdy         (rdy),
    .idu_mat_rf_alu_sel            (sel),
    .idu_mat_rf_alu_gateclk_sel    (gsel),
    .idu_mat_rf_pipe8_iid          (rf_iid),
    .idu_mat_rf_pipe8_alu_meta     (rf_meta),
    .idu_mat_rf_pipe8_alu_src0_vld (rf_s0v),
    .idu_mat_rf_pipe8_alu_src0     (rf_s0),
    .mat_alu_cbus_ex1_pipe8_sel    (csel),
    .mat_alu_cbus_ex1_pipe8_iid    (ciid),
    .idu_mat_pipe8_idle            (idle)
`ifdef MAT_PIPE8_IID_CHK_EN
    ,
    .idu_mat_pipe8_iid_err         (iid_err)
`endif
  );

  initial ctrl_clk = 1'b0;
  always #5 ctrl_clk = ~ctrl_clk;

  task automatic step();
    @(posedge ctrl_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int sent;
    int got;
    int cyc;

    cpurst_b = 1'b0;
    flush    = 1'b0;
    dvld     = 1'b0;
    diid     = '0;
    dmeta    = '0;
    ds0v     = 1'b0;
    ds0      = '0;
    csel     = 1'b0;
    ciid     = '0;
    step();
    step();

    // Reset state
    check("rst_rdy", rdy, 1);
    check("rst_idle", idle, 1);
    check("rst_sel", sel, 0);
    check("rst_gsel", gsel, 0);
    check("rst_iid", rf_iid, 0);
    check("rst_meta", rf_meta, 0);
    check("rst_s0v", rf_s0v, 0);
    check("rst_s0", rf_s0, 0);
`ifdef MAT_PIPE8_IID_CHK_EN
    check("rst_err", iid_err, 0);
`endif
    cpurst_b = 1'b1;
    step();

    // Single instruction: accepted at edge N, launched after edge N+1
    dvld  = 1'b1;
    diid  = 7'h05;
    dmeta = 31'h0011_2345;
    ds0v  = 1'b1;
    ds0   = 64'hDEAD_BEEF_0123_4567;
    step();
    dvld = 1'b0;
    check("t1_sel_n", sel, 0);
    check("t1_idle_drop", idle, 0);
    step();
    check("t1_sel", sel, 1);
    check("t1_gsel", gsel, 1);
    check("t1_iid", rf_iid, 7'h05);
    check("t1_meta", rf_meta, 31'h0011_2345);
    check("t1_s0v", rf_s0v, 1);
    check("t1_s0", rf_s0, 64'hDEAD_BEEF_0123_4567);
    step();
    check("t1_sel_pulse", sel, 0);
    check("t1_gsel_pulse", gsel, 0);
    check("t1_iid_hold", rf_iid, 7'h05);
    check("t1_idle_outst", idle, 0);
    csel = 1'b1;
    ciid = 7'h05;
    step();
    csel = 1'b0;
    check("t1_idle_back", idle, 1);

    // Six back-to-back dispatches, no completions
    ds0v = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      dvld  = 1'b1;
      diid  = 7'(k);
      dmeta = 31'(k);
      step();
      if (k == 2) begin
        check("t2_sel1", sel, 1);
        check("t2_iid1", rf_iid, 7'h01);
      end
      if (k == 3) begin
        check("t2_sel2", sel, 1);
        check("t2_iid2", rf_iid, 7'h02);
      end
      if (k == 4) check("t2_stall", sel, 0);
      if (k == 5) check("t2_rdy_3q", rdy, 1);
      if (k == 6) check("t2_rdy_full", rdy, 0);
    end
    diid = 7'h07;
    step();
    dvld = 1'b0;
    check("t2_full_ignored", rdy, 0);
    check("t2_stall2", sel, 0);
    csel = 1'b1;
    ciid = 7'h01;
    step();
    csel = 1'b0;
    check("t2_cmpl_no_same_edge", sel, 0);
    step();
    check("t2_rel_sel", sel, 1);
    check("t2_rel_iid", rf_iid, 7'h03);
    check("t2_rdy_back", rdy, 1);
    step();
    check("t2_one_only", sel, 0);

    // Same-edge issue and completion with outstanding = 1
    csel = 1'b1;
    ciid = 7'h02;
    step();
    check("t3_dec_sel", sel, 0);
    ciid = 7'h03;
    step();
    csel = 1'b0;
    check("t3_same_sel", sel, 1);
    check("t3_same_iid", rf_iid, 7'h04);
    step();
    check("t3_next_sel", sel, 1);
    check("t3_next_iid", rf_iid, 7'h05);
    step();
    check("t3_cap", sel, 0);

    // Flush with 3 queued and 2 outstanding
    dvld = 1'b1;
    diid = 7'h07;
    step();
    diid = 7'h08;
    step();
    check("t4_pre_rdy", rdy, 1);
    check("t4_pre_idle", idle, 0);
    flush = 1'b1;
    diid  = 7'h09;
    csel  = 1'b1;
    ciid  = 7'h04;
    step();
    flush = 1'b0;
    dvld  = 1'b0;
    csel  = 1'b0;
    check("t4_sel", sel, 0);
    check("t4_gsel", gsel, 0);
    check("t4_idle", idle, 1);
    check("t4_rdy", rdy, 1);
    check("t4_data_hold", rf_iid, 7'h05);
    step();
    step();
    check("t4_no_enq_sel", sel, 0);
    check("t4_no_enq_idle", idle, 1);

    // Streaming with immediate completions across several pointer wraps
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 20 && cyc < 200) begin
      dvld = (sent < 20);
      diid = 7'(32'h30 + sent);
      check("t5_rdy", rdy, 1);
      step();
      cyc++;
      if (dvld) sent++;
      if (sel) begin
        check("t5_order", rf_iid, 7'(32'h30 + got));
        got++;
        csel = 1'b1;
        ciid = rf_iid;
      end else begin
        csel = 1'b0;
      end
    end
    dvld = 1'b0;
    check("t5_count", got, 20);
    check("t5_cycles", cyc, 21);
    step();
    csel = 1'b0;
    step();
    check("t5_idle", idle, 1);

`ifdef MAT_PIPE8_IID_CHK_EN
    // IID mismatch sets the sticky error; flush does not clear it
    dvld = 1'b1;
    diid = 7'h10;
    step();
    dvld = 1'b0;
    step();
    check("t6_iid", rf_iid, 7'h10);
    check("t6_err_pre", iid_err, 0);
    csel = 1'b1;
    ciid = 7'h11;
    step();
    csel = 1'b0;
    check("t6_err", iid_err, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    check("t6_err_sticky", iid_err, 1);
`endif

    // Asynchronous reset in the middle of operation
    dvld = 1'b1;
    diid = 7'h40;
    step();
    dvld = 1'b0;
    step();
    check("t7_pre_sel", sel, 1);
    #2;
    cpurst_b = 1'b0;
    #1;
    check("t7_sel", sel, 0);
    check("t7_iid", rf_iid, 0);
    check("t7_idle", idle, 1);
    check("t7_rdy", rdy, 1);
`ifdef MAT_PIPE8_IID_CHK_EN
    check("t7_err", iid_err, 0);
`endif
    step();
    cpurst_b = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
